instruction_fetch_unit: RTL and testbench
=========================================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 branch_jump_addres  input  32  redirect target from execute stage.
REQ-005 branch_or_jump_signal  input  1  redirect request, valid for one cycle.
REQ-006 stall  input  1  decode stage cannot accept a new instruction.
REQ-007 imem_read  output  1  instruction cache read request.
REQ-008 imem_address  output  32  instruction cache address.
REQ-009 imem_readdata  input  32  instruction word, valid when imem_read=1 and imem_busywait=0.
REQ-010 imem_busywait  input  1  cache busy; the request must be held.
REQ-011 PC  output  32  address of the instruction on the instruction output.
REQ-012 INCREMENTED_PC_by_four  output  32  PC+4 for that instruction.
REQ-013 instruction  output  32  registered instruction word to decode.
REQ-014 if_valid  output  1  instruction/PC/INCREMENTED_PC_by_four are valid.

Function
REQ-015 Internal fetch pointer fpc (32 bit); imem_address SHALL equal fpc whenever imem_read=1.
REQ-016 FSM states SHALL be FETCH, HOLD and DISCARD.
REQ-017 FETCH: imem_read=1. A completion (imem_busywait=0) SHALL write {fpc, fpc+4, imem_readdata} to the output registers and set if_valid=1 next cycle, provided stall=0 or if_valid=0. It SHALL also set fpc<=fpc+4.
REQ-018 FETCH completion while stall=1 and if_valid=1: the word SHALL be captured in a one-entry buffer, fpc<=fpc+4, and the FSM SHALL go to HOLD.
REQ-019 HOLD: imem_read=0 and the outputs hold. When stall=0, the buffer SHALL move to the outputs (if_valid=1) and the FSM SHALL return to FETCH.
REQ-020 Zero-wait throughput SHALL be 1 instruction/cycle. Latency is request in cycle n, if_valid=1 in cycle n+1.
REQ-021 While imem_busywait=1, imem_read and imem_address SHALL stay stable; the request is never withdrawn.
REQ-022 FETCH/HOLD with stall=1 and no completion: the outputs and if_valid SHALL hold.
REQ-023 Redirect (branch_or_jump_signal=1) SHALL take priority over stall and completion:
- next cycle: if_valid=0 and the buffer is cleared;
- fpc<={branch_jump_addres[31:2],2'b00};
- the target's low two bits are ignored.
REQ-024 Redirect while imem_busywait=1 in FETCH: the FSM SHALL go to DISCARD. The fetch pointer keeps the old address on imem_address until completion. The target is latched in a pending register.
REQ-025 DISCARD: imem_read=1 at the old address. On imem_busywait=0, the returned word SHALL be dropped, fpc<=pending target, and the FSM SHALL go to FETCH.
REQ-026 A second redirect in DISCARD SHALL overwrite the pending target.
REQ-027 Redirect in the same cycle as a completion: the completing word SHALL be dropped and the target fetched next cycle.
REQ-028 Redirect in HOLD: the buffer SHALL be dropped and the FSM SHALL go to FETCH at the target.
REQ-029 PC arithmetic SHALL be modulo 2^32: fpc=32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-030 No combinational path SHALL exist from imem_readdata to instruction; all outputs except imem_read and imem_address are registered.

Reset
REQ-031 With RESET=1 at a clock edge:
- fpc<=RESET_PC;
- PC, INCREMENTED_PC_by_four and instruction SHALL be 0; if_valid=0;
- buffer and pending redirect SHALL be cleared; state SHALL be FETCH.
REQ-032 While RESET=1, imem_read SHALL be 0.
REQ-033 In the first cycle after RESET falls, imem_read=1 and imem_address=RESET_PC.
REQ-034 RESET SHALL override an outstanding cache request, and any late completion SHALL be ignored.

Verification
REQ-035 Zero-wait cache with words 0x00000013, 0x00100093, ... after reset -> if_valid=1 from cycle 2; PC sequence 0x0, 0x4, 0x8; INCREMENTED_PC_by_four is PC+4 each cycle.
REQ-036 imem_busywait=1 for 3 cycles on fetch 0x4 -> imem_address=0x4 stable for 4 cycles; if_valid=0 until the word arrives, then PC=0x4.
REQ-037 stall=1 for 2 cycles with PC=0x8 valid -> outputs hold PC=0x8; 0xC is buffered (imem_read=0 in HOLD); 0xC appears in the cycle after stall falls.
REQ-038 Redirect to 0x103 while busywait=1 on 0x10 -> the 0x10 word is dropped; the next imem_address is 0x100; if_valid=0 until PC=0x100 is output.
REQ-039 Redirect together with stall=1 in HOLD -> buffer discarded, if_valid=0 next cycle, fetch at the target.
REQ-040 RESET asserted mid-request with busywait=1 -> next cycle if_valid=0 and imem_read=0; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Purpose: fetches instruction words from the instruction cache and presents them to decode with PC and PC+4.
// Latency: a request completing in cycle n shows if_valid=1 in cycle n+1; 1 instr/cycle with a zero-wait cache.
// Backpressure: a stalled decode parks one completed word in a buffer (HOLD) and pauses fetching until released.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] branch_jump_addres,
  input  logic        branch_or_jump_signal,
  input  logic        stall,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_readdata,
  input  logic        imem_busywait,
  output logic [31:0] PC,
  output logic [31:0] INCREMENTED_PC_by_four,
  output logic [31:0] instruction,
  output logic        if_valid
);

  localparam logic [1:0] FETCH   = 2'd0;
  localparam logic [1:0] HOLD    = 2'd1;
  localparam logic [1:0] DISCARD = 2'd2;

  logic [1:0]  state;
  logic [31:0] fpc;
  logic [31:0] fpc_plus4;
  logic [31:0] pending_target;
  logic [31:0] buf_pc;
  logic [31:0] buf_instr;
  logic [31:0] redir_target;
  logic        redir;
  logic        fetch_done;
  logic        load_out;
  logic        load_buf;
  logic        release_buf;

  // Masking with ~3 word-aligns the target and keeps all input bits in use.
  assign redir_target = branch_jump_addres & ~32'h0000_0003;
  assign redir        = branch_or_jump_signal;
  assign fpc_plus4    = fpc + 32'd4;

  // The request is a pure function of state so it can never drop while the cache is busy.
  assign imem_read    = !RESET && ((state == FETCH) || (state == DISCARD));
  assign imem_address = fpc;

  // A completing word goes straight out if decode can take it, otherwise into the buffer.
  assign fetch_done  = (state == FETCH) && !imem_busywait;
  assign load_out    = fetch_done && !redir && (!stall || !if_valid);
  assign load_buf    = fetch_done && !redir && stall && if_valid;
  assign release_buf = (state == HOLD) && !redir && !stall;

  // Fetch pointer, FSM and pending redirect target; a redirect outranks stall and completion.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state          <= FETCH;
      fpc            <= RESET_PC;
      pending_target <= 32'd0;
    end else begin
      case (state)
        FETCH: begin
          if (redir) begin
            if (imem_busywait) begin
              // Cannot withdraw the in-flight request: keep its address until it retires.
              state          <= DISCARD;
              pending_target <= redir_target;
            end else begin
              fpc <= redir_target;
            end
          end else if (!imem_busywait) begin
            fpc <= fpc_plus4;
            if (load_buf) state <= HOLD;
          end
        end
        HOLD: begin
          if (redir) begin
            fpc   <= redir_target;
            state <= FETCH;
          end else if (!stall) begin
            state <= FETCH;
          end
        end
        DISCARD: begin
          if (redir) pending_target <= redir_target;
          if (!imem_busywait) begin
            // A redirect arriving on the retiring cycle is the newest target.
            fpc   <= redir ? redir_target : pending_target;
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  // Registered decode-facing outputs; readdata only ever reaches them through a flop.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      PC                     <= 32'd0;
      INCREMENTED_PC_by_four <= 32'd0;
      instruction            <= 32'd0;
      if_valid               <= 1'b0;
    end else if (load_out) begin
      PC                     <= fpc;
      INCREMENTED_PC_by_four <= fpc_plus4;
      instruction            <= imem_readdata;
      if_valid               <= 1'b1;
    end else if (release_buf) begin
      PC                     <= buf_pc;
      INCREMENTED_PC_by_four <= buf_pc + 32'd4;
      instruction            <= buf_instr;
      if_valid               <= 1'b1;
    end else if (redir || (state == DISCARD)) begin
      if_valid <= 1'b0;
    end else if ((state == FETCH) && !stall) begin
      // Decode took the current word and nothing new arrived.
      if_valid <= 1'b0;
    end
  end

  // One-entry skid buffer for a word that completes while decode is stalled.
  always_ff @(posedge CLK) begin
    if (RESET || redir) begin
      buf_pc    <= 32'd0;
      buf_instr <= 32'd0;
    end else if (load_buf) begin
      buf_pc    <= fpc;
      buf_instr <= imem_readdata;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench: per-cycle stimulus rows with hand-computed cache-side expectations;
// expected decode-side words go into a queue and a monitor checks every consumed output.
module tb_instruction_fetch_unit;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] branch_jump_addres = 32'd0;
  logic        branch_or_jump_signal = 1'b0;
  logic        stall = 1'b0;
  logic        imem_read;
  logic [31:0] imem_address;
  logic [31:0] imem_readdata;
  logic        imem_busywait = 1'b0;
  logic [31:0] PC;
  logic [31:0] INCREMENTED_PC_by_four;
  logic [31:0] instruction;
  logic        if_valid;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .CLK                    (CLK),
    .RESET                  (RESET),
    .branch_jump_addres     (branch_jump_addres),
    .branch_or_jump_signal  (branch_or_jump_signal),
    .stall                  (stall),
    .imem_read              (imem_read),
    .imem_address           (imem_address),
    .imem_readdata          (imem_readdata),
    .imem_busywait          (imem_busywait),
    .PC                     (PC),
    .INCREMENTED_PC_by_four (INCREMENTED_PC_by_four),
    .instruction            (instruction),
    .if_valid               (if_valid)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], 16'h0013};
  endfunction

  // Instruction memory contents: each word encodes its own address.
  assign imem_readdata = word_at(imem_address);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: any word decode accepts (valid, not stalled, not flushed) must match the queue head.
  always @(negedge CLK) begin
    if (!RESET && if_valid === 1'b1 && !stall && !branch_or_jump_signal) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got PC %h expected none", PC);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("mon_pc", PC, e);
        check("mon_pc4", INCREMENTED_PC_by_four, e + 32'd4);
        check("mon_instr", instruction, word_at(e));
      end
    end
  end

  // One clock of stimulus plus the cache-side view expected in that same cycle.
  task automatic row(input logic rst, input logic st, input logic bz, input logic br,
                     input logic [31:0] tgt, input logic erd, input logic [31:0] eaddr,
                     input logic evld, input logic psh, input logic [31:0] epc);
    @(posedge CLK);
    #1;
    RESET                 = rst;
    stall                 = st;
    imem_busywait         = bz;
    branch_or_jump_signal = br;
    branch_jump_addres    = tgt;
    if (psh) exp_q.push_back(epc);
    @(negedge CLK);
    check("imem_read", {31'd0, imem_read}, {31'd0, erd});
    if (erd) check("imem_address", imem_address, eaddr);
    check("if_valid", {31'd0, if_valid}, {31'd0, evld});
  endtask

  initial begin
    // Reset: no request, registered outputs cleared.
    row(1, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0);
    row(1, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0);
    check("reset_pc", PC, 32'h0);
    check("reset_pc4", INCREMENTED_PC_by_four, 32'h0);
    check("reset_instr", instruction, 32'h0);
    // Zero-wait start, then busywait for 3 cycles on 0x4.
    row(0, 0, 0, 0, 32'h0, 1, 32'h0,   0, 0, 32'h0);
    row(0, 0, 1, 0, 32'h0, 1, 32'h4,   1, 1, 32'h0);
    row(0, 0, 1, 0, 32'h0, 1, 32'h4,   0, 0, 32'h0);
    row(0, 0, 1, 0, 32'h0, 1, 32'h4,   0, 0, 32'h0);
    row(0, 0, 0, 0, 32'h0, 1, 32'h4,   0, 0, 32'h0);
    row(0, 0, 0, 0, 32'h0, 1, 32'h8,   1, 1, 32'h4);
    // Stall with PC=0x8 valid: 0xC parked, outputs hold, released after stall falls.
    row(0, 1, 0, 0, 32'h0, 1, 32'hC,   1, 0, 32'h0);
    row(0, 1, 0, 0, 32'h0, 0, 32'h0,   1, 0, 32'h0);
    check("hold_pc", PC, 32'h8);
    check("hold_instr", instruction, word_at(32'h8));
    row(0, 0, 0, 0, 32'h0, 0, 32'h0,   1, 1, 32'h8);
    // Redirect to 0x103 while 0x10 is outstanding.
    row(0, 0, 1, 0, 32'h0, 1, 32'h10,  1, 1, 32'hC);
    row(0, 0, 1, 1, 32'h103, 1, 32'h10, 0, 0, 32'h0);
    row(0, 0, 1, 0, 32'h0, 1, 32'h10,  0, 0, 32'h0);
    row(0, 0, 0, 0, 32'h0, 1, 32'h10,  0, 0, 32'h0);
    row(0, 0, 0, 0, 32'h0, 1, 32'h100, 0, 0, 32'h0);
    row(0, 0, 0, 0, 32'h0, 1, 32'h104, 1, 1, 32'h100);
    // Redirect during HOLD drops the buffered 0x108.
    row(0, 1, 0, 0, 32'h0, 1, 32'h108, 1, 0, 32'h0);
    row(0, 1, 0, 1, 32'h40, 0, 32'h0,  1, 0, 32'h0);
    row(0, 0, 0, 0, 32'h0, 1, 32'h40,  0, 0, 32'h0);
    // Redirect on the same cycle as a completion drops the completing 0x44.
    row(0, 0, 0, 1, 32'h80, 1, 32'h44, 1, 0, 32'h0);
    row(0, 0, 0, 0, 32'h0, 1, 32'h80,  0, 0, 32'h0);
    row(0, 0, 1, 0, 32'h0, 1, 32'h84,  1, 1, 32'h80);
    // Reset while a request is outstanding; late busy is ignored.
    row(1, 0, 1, 0, 32'h0, 0, 32'h0,   0, 0, 32'h0);
    row(1, 0, 1, 0, 32'h0, 0, 32'h0,   0, 0, 32'h0);
    row(0, 0, 0, 0, 32'h0, 1, 32'h0,   0, 0, 32'h0);
    // Unaligned redirect to the top of memory, then wrap to 0.
    row(0, 0, 0, 1, 32'hFFFF_FFFF, 1, 32'h4, 1, 0, 32'h0);
    row(0, 0, 0, 0, 32'h0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0);
    row(0, 0, 0, 0, 32'h0, 1, 32'h0,   1, 1, 32'hFFFF_FFFC);
    row(0, 0, 1, 0, 32'h0, 1, 32'h4,   1, 1, 32'h0);
    // Two redirects while discarding: the later target wins.
    row(0, 0, 1, 1, 32'h300, 1, 32'h4, 0, 0, 32'h0);
    row(0, 0, 1, 1, 32'h204, 1, 32'h4, 0, 0, 32'h0);
    row(0, 0, 0, 0, 32'h0, 1, 32'h4,   0, 0, 32'h0);
    row(0, 0, 0, 0, 32'h0, 1, 32'h204, 0, 0, 32'h0);
    row(0, 0, 0, 0, 32'h0, 1, 32'h208, 1, 1, 32'h204);
    row(0, 0, 0, 0, 32'h0, 1, 32'h20C, 1, 1, 32'h208);
    @(posedge CLK);
    #1;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
